// File: rtl/sobel_window_gen.sv
// Builds the eight-neighbour 3x3 window around each interior pixel of a raster stream,
// using two row buffers plus short column shift registers so no frame store is needed.
module sobel_window_gen #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 128
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 pix_in,
  input  logic                       pix_valid,
  output logic [7:0]                 p0,
  output logic [7:0]                 p1,
  output logic [7:0]                 p2,
  output logic [7:0]                 p3,
  output logic [7:0]                 p5,
  output logic [7:0]                 p6,
  output logic [7:0]                 p7,
  output logic [7:0]                 p8,
  output logic                       win_valid,
  output logic [$clog2(WIDTH)-1:0]   win_x,
  output logic [$clog2(DEPTH)-1:0]   win_y,
  output logic                       frame_done
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(DEPTH);
  localparam logic [XW-1:0] LAST_X = XW'(WIDTH - 1);
  localparam logic [XW-1:0] TWO_X  = XW'(2);
  localparam logic [XW-1:0] ONE_X  = XW'(1);
  localparam logic [YW-1:0] LAST_Y = YW'(DEPTH - 1);
  localparam logic [YW-1:0] ONE_Y  = YW'(1);

  localparam logic ST_FILL = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  logic [7:0]    r_lb0 [WIDTH];
  logic [7:0]    r_lb1 [WIDTH];
  logic [XW-1:0] r_col;
  logic [YW-1:0] r_row;
  logic          r_state;
  logic [7:0]    r_cur1, r_cur2;
  logic [7:0]    r_mid1, r_mid2;
  logic [7:0]    r_top1, r_top2;

  logic [7:0] w_lb0Out;
  logic [7:0] w_lb1Out;
  logic       w_lastCol;
  logic       w_lastRow;
  logic       w_emit;

  assign w_lb0Out  = r_lb0[r_col];
  assign w_lb1Out  = r_lb1[r_col];
  assign w_lastCol = (r_col == LAST_X);
  assign w_lastRow = (r_row == LAST_Y);
  // RUN covers rows 2 and up, so only the column still needs qualifying here.
  assign w_emit    = pix_valid && (r_state == ST_RUN) && (r_col >= TWO_X);

  // Row buffers age by one row per accepted pixel; contents need no reset.
  always_ff @(posedge clk) begin
    if (!rst && pix_valid) begin
      r_lb1[r_col] <= pix_in;
      r_lb0[r_col] <= w_lb1Out;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col      <= '0;
      r_row      <= '0;
      r_state    <= ST_FILL;
      r_cur1     <= '0;
      r_cur2     <= '0;
      r_mid1     <= '0;
      r_mid2     <= '0;
      r_top1     <= '0;
      r_top2     <= '0;
      p0         <= '0;
      p1         <= '0;
      p2         <= '0;
      p3         <= '0;
      p5         <= '0;
      p6         <= '0;
      p7         <= '0;
      p8         <= '0;
      win_x      <= '0;
      win_y      <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      win_valid  <= w_emit;
      frame_done <= w_emit && w_lastCol && w_lastRow;
      if (pix_valid) begin
        r_cur1 <= pix_in;
        r_cur2 <= r_cur1;
        r_mid1 <= w_lb1Out;
        r_mid2 <= r_mid1;
        r_top1 <= w_lb0Out;
        r_top2 <= r_top1;
        if (w_lastCol) begin
          r_col <= '0;
          r_row <= w_lastRow ? '0 : r_row + ONE_Y;
        end else begin
          r_col <= r_col + ONE_X;
        end
        if (r_state == ST_FILL && w_lastCol && r_row == ONE_Y) begin
          r_state <= ST_RUN;
        end else if (r_state == ST_RUN && w_lastCol && w_lastRow) begin
          r_state <= ST_FILL;
        end
      end
      // Window taps: top row from LB0, centre row from LB1, bottom row from the live stream.
      if (w_emit) begin
        p0    <= r_top2;
        p1    <= r_top1;
        p2    <= w_lb0Out;
        p3    <= r_mid2;
        p5    <= w_lb1Out;
        p6    <= r_cur2;
        p7    <= r_cur1;
        p8    <= pix_in;
        win_x <= r_col - ONE_X;
        win_y <= r_row - ONE_Y;
      end
    end
  end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed-sequence bench for sobel_window_gen: an 8x8 instance for the ramp scenarios and
// a default 128x128 instance for a random frame, both checked against an image-array model.
module tb_sobel_window_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] pixIn;
  logic       valid8;
  logic       valid128;

  logic [7:0] s0, s1, s2, s3, s5, s6, s7, s8;
  logic       sValid, sDone;
  logic [2:0] sX, sY;

  logic [7:0] b0, b1, b2, b3, b5, b6, b7, b8;
  logic       bValid, bDone;
  logic [6:0] bX, bY;

  sobel_window_gen #(.WIDTH(8), .DEPTH(8)) dutSmall (
    .clk(clk), .rst(rst), .pix_in(pixIn), .pix_valid(valid8),
    .p0(s0), .p1(s1), .p2(s2), .p3(s3), .p5(s5), .p6(s6), .p7(s7), .p8(s8),
    .win_valid(sValid), .win_x(sX), .win_y(sY), .frame_done(sDone)
  );

  sobel_window_gen dutLarge (
    .clk(clk), .rst(rst), .pix_in(pixIn), .pix_valid(valid128),
    .p0(b0), .p1(b1), .p2(b2), .p3(b3), .p5(b5), .p6(b6), .p7(b7), .p8(b8),
    .win_valid(bValid), .win_x(bX), .win_y(bY), .frame_done(bDone)
  );

  int          mode;
  int          mW, mD;
  logic [63:0] obsWin;
  logic [7:0]  obsX, obsY;
  logic        obsValid, obsDone;

  // Present whichever instance is under test through one set of observed signals.
  always_comb begin
    obsWin   = '0;
    obsX     = '0;
    obsY     = '0;
    obsValid = 1'b0;
    obsDone  = 1'b0;
    if (mode == 0) begin
      obsWin   = {s0, s1, s2, s3, s5, s6, s7, s8};
      obsX     = 8'(sX);
      obsY     = 8'(sY);
      obsValid = sValid;
      obsDone  = sDone;
    end else begin
      obsWin   = {b0, b1, b2, b3, b5, b6, b7, b8};
      obsX     = 8'(bX);
      obsY     = 8'(bY);
      obsValid = bValid;
      obsDone  = bDone;
    end
  end

  logic [7:0]  img [128][128];
  int          mr, mc;
  logic [63:0] expWin;
  logic [7:0]  expX, expY;
  logic        expValid, expDone;
  int          checks = 0;
  int          errors = 0;
  int          winCount;
  logic [63:0] firstWin;
  logic [7:0]  firstX, firstY;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    checkOutput("win_valid", 64'(obsValid), 64'(expValid));
    checkOutput("frame_done", 64'(obsDone), 64'(expDone));
    checkOutput("window", obsWin, expWin);
    checkOutput("win_x", 64'(obsX), 64'(expX));
    checkOutput("win_y", 64'(obsY), 64'(expY));
  endtask

  // One clock of stimulus; the model keeps the whole image and reads neighbours from it.
  task automatic applyStimulus(input logic [7:0] p, input logic v);
    pixIn    = p;
    valid8   = (mode == 0) && v;
    valid128 = (mode == 1) && v;
    @(posedge clk);
    if (v) begin
      img[mr][mc] = p;
      expValid    = (mr >= 2) && (mc >= 2);
      expDone     = (mr == mD - 1) && (mc == mW - 1);
      if (expValid) begin
        expWin = {img[mr-2][mc-2], img[mr-2][mc-1], img[mr-2][mc],
                  img[mr-1][mc-2], img[mr-1][mc],
                  img[mr][mc-2],   img[mr][mc-1],   img[mr][mc]};
        expX   = 8'(mc - 1);
        expY   = 8'(mr - 1);
      end
      mc++;
      if (mc == mW) begin
        mc = 0;
        mr++;
        if (mr == mD) mr = 0;
      end
    end else begin
      expValid = 1'b0;
      expDone  = 1'b0;
    end
    #1;
    checkAll();
    if (obsValid) begin
      if (winCount == 0) begin
        firstWin = obsWin;
        firstX   = obsX;
        firstY   = obsY;
      end
      winCount++;
    end
    valid8   = 1'b0;
    valid128 = 1'b0;
  endtask

  task automatic resetDut();
    rst      = 1'b1;
    pixIn    = 8'($urandom);
    valid8   = 1'b1;
    valid128 = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    valid8   = 1'b0;
    valid128 = 1'b0;
    mr       = 0;
    mc       = 0;
    expValid = 1'b0;
    expDone  = 1'b0;
    expWin   = '0;
    expX     = '0;
    expY     = '0;
    checkAll();
  endtask

  // kind 0: ramp, 1: inverted ramp, 2: random; optional random idle gaps between pixels.
  task automatic sendFrame(input int kind, input bit gaps, input int limit);
    logic [7:0] p;
    for (int i = 0; i < limit; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) != 0) applyStimulus(8'($urandom), 1'b0);
      end
      case (kind)
        0:       p = 8'(i);
        1:       p = 8'(255 - i);
        default: p = 8'($urandom);
      endcase
      applyStimulus(p, 1'b1);
    end
  endtask

  initial begin
    mode     = 0;
    mW       = 8;
    mD       = 8;
    rst      = 1'b0;
    pixIn    = '0;
    valid8   = 1'b0;
    valid128 = 1'b0;
    winCount = 0;
    firstWin = '0;
    firstX   = '0;
    firstY   = '0;
    @(posedge clk);
    resetDut();

    winCount = 0;
    sendFrame(0, 1'b0, 64);
    checkOutput("ramp_count", 64'(winCount), 64'd36);
    checkOutput("ramp_first_win", firstWin, 64'h000102080A101112);
    checkOutput("ramp_first_x", 64'(firstX), 64'd1);
    checkOutput("ramp_first_y", 64'(firstY), 64'd1);
    checkOutput("ramp_last_x", 64'(obsX), 64'd6);
    checkOutput("ramp_last_y", 64'(obsY), 64'd6);
    checkOutput("ramp_last_p8", 64'(obsWin[7:0]), 64'd63);

    winCount = 0;
    sendFrame(0, 1'b1, 64);
    checkOutput("gap_count", 64'(winCount), 64'd36);

    winCount = 0;
    sendFrame(1, 1'b0, 64);
    checkOutput("inv_count", 64'(winCount), 64'd36);
    checkOutput("inv_first_p0", 64'(firstWin[63:56]), 64'd255);
    checkOutput("inv_first_p8", 64'(firstWin[7:0]), 64'd237);
    checkOutput("inv_first_x", 64'(firstX), 64'd1);
    checkOutput("inv_first_y", 64'(firstY), 64'd1);

    sendFrame(0, 1'b0, 30);
    resetDut();
    winCount = 0;
    sendFrame(0, 1'b0, 64);
    checkOutput("post_reset_count", 64'(winCount), 64'd36);
    checkOutput("post_reset_first", firstWin, 64'h000102080A101112);

    mode = 1;
    mW   = 128;
    mD   = 128;
    resetDut();
    winCount = 0;
    sendFrame(2, 1'b0, 128 * 128);
    checkOutput("large_count", 64'(winCount), 64'd15876);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
Upstream neighbour of the Sobel edge stage. Accepts a raster-order 8-bit grayscale pixel stream, one pixel per accepted cycle. Buffers the two previous image rows and emits, for every interior pixel, the eight-neighbour 3x3 window p0..p8 (centre excluded) with its centre coordinates. The Sobel stage consumes these windows directly instead of indexing a whole frame.

Parameters:
WIDTH, 128, image columns per row (>= 3)
DEPTH, 128, image rows per frame (>= 3)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
pix_in  input  8  incoming pixel, raster order (row 0 col 0 first)
pix_valid  input  1  pix_in accepted this cycle; no backpressure, gaps allowed
p0,p1,p2  output  8 each  window row above centre: left, middle, right
p3,p5  output  8 each  centre row: left, right
p6,p7,p8  output  8 each  window row below centre: left, middle, right
win_valid  output  1  one-cycle strobe, p0..p8/win_x/win_y valid
win_x  output  clog2(WIDTH)  centre column X, 1..WIDTH-2
win_y  output  clog2(DEPTH)  centre row Y, 1..DEPTH-2
frame_done  output  1  one-cycle strobe after the last pixel of a frame is accepted

Behaviour:
- Reset: on rst=1 at a clock edge, all outputs go to 0. Column/row counters go to 0. FSM goes to FILL. Line-buffer RAM contents are don't-care and are never emitted before being rewritten. pix_valid is ignored while rst=1. Reset mid-frame discards the partial frame; the next accepted pixel is (0,0).
- Storage: two line buffers, WIDTH x 8 each: LB1 = previous row, LB0 = the row before LB1. Two 2-deep shift registers per row, for the current row, LB1 output and LB0 output, give the columns c-1 and c-2.
- On an accepted pixel at (r,c):
  - Write pix_in into LB1[c].
  - The old LB1[c] moves into LB0[c].
  - Advance c. At c=WIDTH-1, wrap c to 0 and increment r. At r=DEPTH-1,c=WIDTH-1, wrap both to 0.
- Window mapping for an accepted pixel at (r,c) with r>=2 and c>=2; the centre is (r-1,c-1):
  - p0=(r-2,c-2), p1=(r-2,c-1), p2=(r-2,c)
  - p3=(r-1,c-2), p5=(r-1,c)
  - p6=(r,c-2), p7=(r,c-1), p8=(r,c) = pix_in
- Latency: outputs are registered. win_valid, p0..p8, win_x=c-1 and win_y=r-1 are asserted the cycle after the accepting edge.
- win_valid is 0 for pixels with r<2 or c<2. Each frame yields exactly (WIDTH-2)*(DEPTH-2) strobes. Border pixels produce no window; the downstream stage marks them non-edge.
- Shift registers are not reset at row wrap. Columns 0 and 1 of each row refill them before any window is emitted.
- Data outputs hold their last value when win_valid=0.
- FSM:
  - FILL: rows 0-1, no windows. Go to RUN when the pixel at (1,WIDTH-1) is accepted.
  - RUN: emit windows per the mapping above. Go to FILL when the pixel at (DEPTH-1,WIDTH-1) is accepted.
- frame_done: pulses in the same cycle as the final window strobe of the frame.
- Idle cycles (pix_valid=0) change no state and force win_valid=0 and frame_done=0.
- Back-to-back frames: the pixel after the frame's last pixel is (0,0) of the next frame, with no gap required.
- Arithmetic: counters are unsigned and wrap only by explicit compare, never by overflow. No arithmetic is performed on pixel data.

Test Plan:
- WIDTH=DEPTH=8, ramp image pix=(8r+c) mod 256, continuous valid -> first win_valid one cycle after pixel index 18 is accepted. win_x=1, win_y=1, p0=0, p1=1, p2=2, p3=8, p5=10, p6=16, p7=17, p8=18.
- Same ramp -> exactly 36 win_valid strobes. None follow pixels with c<2 or r<2. The last strobe has win_x=6, win_y=6, p8=63 and coincides with frame_done.
- Same ramp with pix_valid toggling 1,0,0,1 pseudo-randomly -> identical window sequence to continuous valid. Strobes occur only one cycle after accepting edges.
- Two back-to-back 8x8 frames; frame 2 uses pix=255-(8r+c) -> frame 2's first window has p0=255, p8=237, win_x=1, win_y=1. No window mixes frame-1 data with frame-2 data.
- rst pulsed for one cycle after 30 pixels, then a full ramp frame -> outputs are 0 during reset, and 36 correct windows follow as in the first scenario.
- Default WIDTH=DEPTH=128 with random pixels vs a reference model -> 15876 windows, all matching bit-exactly.
